// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Collects a valid/ready byte stream, packs every four bytes little-endian into a
// 32-bit word and writes the words to consecutive word addresses, starting at
// byte address 0. The core is held stalled for the whole load. done pulses once
// when the requested number of words has been written.
//
// Ports
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   start        request a load (only honoured in IDLE)
//   word_count   words to load, sampled with an accepted start, clamped to 2**ADDR_W
//   byte_valid   byte_data carries a byte this cycle
//   byte_data    incoming byte
//   byte_ready   loader takes a byte this cycle (high only while receiving)
//   mem_we       one-cycle write strobe per assembled word
//   mem_addr     byte address of the write (word index in [ADDR_W+1:2])
//   mem_wdata    assembled word
//   busy         load in progress
//   cpu_stall    same as busy; the core must not fetch while high
//   done         one-cycle pulse after the last word has been written
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              cpu_stall,
  output logic              done
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1 << ADDR_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  n_words, n_words_next;
  logic [CNT_W-1:0]  word_idx, word_idx_next;
  logic [1:0]        byte_idx, byte_idx_next;
  logic [23:0]       shift, shift_next;
  logic [31:0]       addr_next, wdata_next;

  // State and datapath registers. The status outputs are registered decodes of
  // the next state, so each one equals a decode of the current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      n_words    <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      shift      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      cpu_stall  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      n_words    <= n_words_next;
      word_idx   <= word_idx_next;
      byte_idx   <= byte_idx_next;
      shift      <= shift_next;
      mem_addr   <= addr_next;
      mem_wdata  <= wdata_next;
      byte_ready <= (state_next == RECV);
      mem_we     <= (state_next == WRITE);
      busy       <= (state_next != IDLE);
      cpu_stall  <= (state_next != IDLE);
      done       <= (state_next == DONE);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_next    = state;
    n_words_next  = n_words;
    word_idx_next = word_idx;
    byte_idx_next = byte_idx;
    shift_next    = shift;
    addr_next     = mem_addr;
    wdata_next    = mem_wdata;

    unique case (state)
      IDLE: begin
        if (start) begin
          n_words_next  = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
          word_idx_next = '0;
          byte_idx_next = '0;
          state_next    = (word_count == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (byte_valid) begin
          byte_idx_next = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            // Fourth byte goes straight into the output word; the write
            // strobe follows in the next cycle.
            state_next = WRITE;
            addr_next  = 32'({word_idx[ADDR_W-1:0], 2'b00});
            wdata_next = {byte_data, shift};
          end else begin
            shift_next[{byte_idx[1:0], 3'b000} +: 8] = byte_data;
          end
        end
      end
      WRITE: begin
        word_idx_next = word_idx + CNT_W'(1);
        state_next    = ((word_idx + CNT_W'(1)) == n_words) ? DONE : RECV;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives byte streams, queues the expected
// memory writes, and pops/compares them as mem_we pulses are observed.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              cpu_stall;
  logic              done;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .cpu_stall  (cpu_stall),
    .done       (done)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  byte_q[$];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          write_cnt = 0;
  int          done_cnt  = 0;
  logic [31:0] last_addr = '0;
  bit          prev_done = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Write/done monitor: scoreboard pop on each write strobe.
  always @(negedge clk) begin
    wr_t e;
    if (prev_done) chk("busy_after_done", 32'(busy), 32'd0);
    if (mem_we === 1'b1) begin
      chk("ready_in_write", 32'(byte_ready), 32'd0);
      chk("stall_in_write", 32'(cpu_stall), 32'd1);
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
      end
      write_cnt++;
      last_addr = mem_addr;
    end
    if (done === 1'b1) begin
      done_cnt++;
      chk("busy_with_done", 32'(busy), 32'd1);
    end
    prev_done = (done === 1'b1);
  end

  task automatic pulse_start(input int wc);
    @(negedge clk);
    start = 1'b1;
    word_count = (ADDR_W+1)'(wc);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Stream byte_q; with gaps, valid drops only between transfers.
  task automatic send_bytes(input bit gaps);
    int idx = 0;
    int cyc = 0;
    int lim = 10 * byte_q.size() + 50;
    bit pending = 1'b0;
    while (idx < byte_q.size() && cyc < lim) begin
      @(negedge clk);
      cyc++;
      if (!pending && gaps && $urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_data  = byte_q[idx];
        pending    = 1'b1;
      end
      if (byte_valid && byte_ready) begin
        idx++;
        pending = 1'b0;
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    chk("bytes_sent", 32'(idx), 32'(byte_q.size()));
  endtask

  task automatic wait_done(input int base, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (done_cnt != base) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    int wb;
    int db;
    logic [7:0] b0, b1, b2, b3;

    rst_n = 1'b0;
    start = 1'b1;
    word_count = '0;
    byte_valid = 1'b1;
    byte_data = 8'hFF;

    // Reset held with start and byte_valid asserted.
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_writes", 32'(write_cnt), 32'd0);
    start = 1'b0;
    byte_valid = 1'b0;
    rst_n = 1'b1;
    idle(2);

    // Basic two-word load with valid held.
    wb = write_cnt; db = done_cnt;
    byte_q = '{8'h93, 8'h00, 8'hA0, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
    push_exp(32'h0, 32'h00A00093);
    push_exp(32'h4, 32'h00100113);
    pulse_start(2);
    send_bytes(1'b0);
    wait_done(db, 10);
    idle(3);
    chk("basic_writes", 32'(write_cnt - wb), 32'd2);
    chk("basic_dones", 32'(done_cnt - db), 32'd1);
    chk("basic_q_empty", 32'(exp_q.size()), 32'd0);

    // Same load with random gaps in byte_valid.
    for (int rep = 0; rep < 3; rep++) begin
      wb = write_cnt; db = done_cnt;
      push_exp(32'h0, 32'h00A00093);
      push_exp(32'h4, 32'h00100113);
      pulse_start(2);
      send_bytes(1'b1);
      wait_done(db, 10);
      idle(3);
      chk("gap_writes", 32'(write_cnt - wb), 32'd2);
      chk("gap_dones", 32'(done_cnt - db), 32'd1);
      chk("gap_q_empty", 32'(exp_q.size()), 32'd0);
    end

    // Zero-length load: done without any write.
    wb = write_cnt; db = done_cnt;
    pulse_start(0);
    wait_done(db, 2);
    idle(3);
    chk("zero_writes", 32'(write_cnt - wb), 32'd0);
    chk("zero_dones", 32'(done_cnt - db), 32'd1);

    // Oversized count clamps to the full memory depth.
    wb = write_cnt; db = done_cnt;
    byte_q.delete();
    for (int w = 0; w < 256; w++) begin
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
      byte_q.push_back(b0); byte_q.push_back(b1);
      byte_q.push_back(b2); byte_q.push_back(b3);
      push_exp(32'(w) * 32'd4, {b3, b2, b1, b0});
    end
    pulse_start(300);
    send_bytes(1'b0);
    wait_done(db, 10);
    idle(3);
    chk("clamp_writes", 32'(write_cnt - wb), 32'd256);
    chk("clamp_last_addr", last_addr, 32'h3FC);
    chk("clamp_dones", 32'(done_cnt - db), 32'd1);
    chk("clamp_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset after six bytes of a two-word load.
    wb = write_cnt; db = done_cnt;
    byte_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    push_exp(32'h0, 32'h44332211);
    pulse_start(2);
    send_bytes(1'b0);
    rst_n = 1'b0;
    idle(2);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(byte_ready), 32'd0);
    rst_n = 1'b1;
    idle(4);
    chk("abort_writes", 32'(write_cnt - wb), 32'd1);
    chk("abort_dones", 32'(done_cnt - db), 32'd0);
    chk("abort_q_empty", 32'(exp_q.size()), 32'd0);

    // Fresh one-word load after the abort starts at address 0 again.
    wb = write_cnt; db = done_cnt;
    byte_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    push_exp(32'h0, 32'hDEADBEEF);
    pulse_start(1);
    send_bytes(1'b0);
    wait_done(db, 10);
    idle(3);
    chk("reload_writes", 32'(write_cnt - wb), 32'd1);
    chk("reload_dones", 32'(done_cnt - db), 32'd1);

    // start pulsed mid-load must be ignored.
    wb = write_cnt; db = done_cnt;
    push_exp(32'h0, 32'h0A0B0C0D);
    pulse_start(1);
    byte_q = '{8'h0D, 8'h0C};
    send_bytes(1'b0);
    pulse_start(5);
    byte_q = '{8'h0B, 8'h0A};
    send_bytes(1'b0);
    wait_done(db, 10);
    idle(6);
    chk("busy_start_writes", 32'(write_cnt - wb), 32'd1);
    chk("busy_start_dones", 32'(done_cnt - db), 32'd1);
    chk("busy_start_idle", 32'(busy), 32'd0);
    chk("busy_start_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
